// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries D-stage prediction to M and redirects fetch.
// Optional perf counters enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallE,
  input  logic            flushE,
  input  logic            stallM,
  input  logic            flushM,
  input  logic            branchD,
  input  logic            pred_takeD,
  input  logic [PC_W-1:0] pcD,
  input  logic [PC_W-1:0] targetD,
  input  logic            actual_takeE,
  output logic            branchM,
  output logic            actual_takeM,
  output logic [PC_W-1:0] pcM,
  output logic            mispredM,
  output logic [PC_W-1:0] redirect_pcM
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] br_cntM,
  output logic [CNT_W-1:0] mispred_cntM
`endif
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FIRED = 1'b1
  } state_t;

  logic            r_branchE;
  logic            r_pred_takeE;
  logic [PC_W-1:0] r_pcE;
  logic [PC_W-1:0] r_targetE;

  logic            r_branchM;
  logic            r_pred_takeM;
  logic            r_actual_takeM;
  logic [PC_W-1:0] r_pcM;
  logic [PC_W-1:0] r_redirect_pcM;

  state_t          r_state;

  logic            w_mispred_raw;
  logic [PC_W-1:0] w_redirect_nxt;

  // Recovery PC chosen in E so the M copy clears to 0 with the stage.
  assign w_redirect_nxt = actual_takeE ? r_targetE
                                       : r_pcE + PC_W'(8);

  // D->E pipeline register: flush beats stall.
  always_ff @(posedge clk) begin
    if (rst | flushE) begin
      r_branchE    <= 1'b0;
      r_pred_takeE <= 1'b0;
      r_pcE        <= '0;
      r_targetE    <= '0;
    end else if (~stallE) begin
      r_branchE    <= branchD;
      r_pred_takeE <= pred_takeD & branchD;
      r_pcE        <= pcD;
      r_targetE    <= targetD;
    end
  end

  // E->M pipeline register, capturing the resolved direction.
  always_ff @(posedge clk) begin
    if (rst | flushM) begin
      r_branchM      <= 1'b0;
      r_pred_takeM   <= 1'b0;
      r_actual_takeM <= 1'b0;
      r_pcM          <= '0;
      r_redirect_pcM <= '0;
    end else if (~stallM) begin
      r_branchM      <= r_branchE;
      r_pred_takeM   <= r_pred_takeE;
      r_actual_takeM <= actual_takeE;
      r_pcM          <= r_pcE;
      r_redirect_pcM <= w_redirect_nxt;
    end
  end

  assign w_mispred_raw = r_branchM &
                         (r_pred_takeM != r_actual_takeM);

  // Redirect FSM: a stalled mispredict fires only once.
  always_ff @(posedge clk) begin
    if (rst | flushM) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_mispred_raw & stallM) r_state <= S_FIRED;
        S_FIRED: if (~stallM) r_state <= S_IDLE;
      endcase
    end
  end

  assign mispredM     = w_mispred_raw & (r_state == S_IDLE);
  assign branchM      = r_branchM;
  assign actual_takeM = r_actual_takeM;
  assign pcM          = r_pcM;
  assign redirect_pcM = r_redirect_pcM;

`ifdef BRU_PERF_CNT_EN
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mis_cnt;

  // Saturating branch and mispredict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (r_branchM & ~stallM & ~(&r_br_cnt))
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (mispredM & ~(&r_mis_cnt))
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign br_cntM      = r_br_cnt;
  assign mispred_cntM = r_mis_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
// Random and directed stimulus against a stage-level reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallE, flushE, stallM, flushM;
  logic        branchD, pred_takeD, actual_takeE;
  logic [31:0] pcD, targetD;
  logic        branchM, actual_takeM, mispredM;
  logic [31:0] pcM, redirect_pcM;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] br_cntM, mispred_cntM;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst),
    .stallE(stallE), .flushE(flushE),
    .stallM(stallM), .flushM(flushM),
    .branchD(branchD), .pred_takeD(pred_takeD),
    .pcD(pcD), .targetD(targetD),
    .actual_takeE(actual_takeE),
    .branchM(branchM), .actual_takeM(actual_takeM),
    .pcM(pcM), .mispredM(mispredM),
    .redirect_pcM(redirect_pcM)
`ifdef BRU_PERF_CNT_EN
    , .br_cntM(br_cntM), .mispred_cntM(mispred_cntM)
`endif
  );

  // Reference model: one instruction record per stage.
  typedef struct packed {
    logic        br;
    logic        pred;
    logic        act;
    logic [31:0] pc;
    logic [31:0] tgt;
  } slot_t;

  slot_t       me, mm;
  bit          redirected;
  int unsigned cb, cm;

  function automatic logic exp_mis();
    return mm.br && (mm.pred != mm.act) && !redirected;
  endfunction

  function automatic logic [31:0] exp_redir();
    return mm.act ? mm.tgt : mm.pc + 32'd8;
  endfunction

  task automatic idle();
    rst = 0; stallE = 0; flushE = 0; stallM = 0; flushM = 0;
    branchD = 0; pred_takeD = 0; pcD = 0; targetD = 0;
    actual_takeE = 0;
  endtask

  task automatic put_br(input logic p, input logic [31:0] pc,
                        input logic [31:0] t);
    branchD = 1; pred_takeD = p; pcD = pc; targetD = t;
  endtask

  task automatic tick();
    logic  mis;
    slot_t ne;
    @(posedge clk);
    mis = exp_mis();
    if (rst) begin
      cb = 0; cm = 0;
    end else begin
      if (mm.br && !stallM && cb != 32'hFFFFFFFF) cb++;
      if (mis && cm != 32'hFFFFFFFF) cm++;
    end
    if (rst || flushM) redirected = 0;
    else if (stallM) redirected = redirected | mis;
    else redirected = 0;
    if (rst || flushM) mm = '0;
    else if (!stallM) begin
      mm = me;
      mm.act = actual_takeE;
    end
    ne = '{br: branchD, pred: pred_takeD, act: 1'b0,
           pc: pcD, tgt: targetD};
    if (rst || flushE) me = '0;
    else if (!stallE) me = ne;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst = 1;
      stallE = 1'($urandom); flushE = 1'($urandom);
      stallM = 1'($urandom); flushM = 1'($urandom);
      branchD = 1'($urandom); pred_takeD = 1'($urandom);
      pcD = $urandom; targetD = $urandom;
      actual_takeE = 1'($urandom);
      tick();
      n_total++;
      if ({branchM, actual_takeM, pcM, mispredM, redirect_pcM}
          !== 67'd0)
        $display("FAIL reset%0d: got br=%b act=%b pc=%h mis=%b rpc=%h, want all 0",
                 i, branchM, actual_takeM, pcM, mispredM, redirect_pcM);
      else n_pass++;
`ifdef BRU_PERF_CNT_EN
      n_total++;
      if ({br_cntM, mispred_cntM} !== 64'd0)
        $display("FAIL reset_cnt: got %0d/%0d, want 0/0",
                 br_cntM, mispred_cntM);
      else n_pass++;
`endif
    end
    idle();
  endtask

  task automatic test_correct_taken();
    idle(); put_br(1, 32'h00400010, 32'h00400100);
    tick();
    idle(); actual_takeE = 1;
    tick();
    n_total++;
    if ({branchM, actual_takeM, pcM, mispredM} !==
        {1'b1, 1'b1, 32'h00400010, 1'b0})
      $display("FAIL correct_taken: got br=%b act=%b pc=%h mis=%b, want 1 1 00400010 0",
               branchM, actual_takeM, pcM, mispredM);
    else n_pass++;
    idle(); tick();
  endtask

  task automatic test_mispred_not_taken();
    idle(); put_br(0, 32'h00400010, 32'h00400100);
    tick();
    idle(); actual_takeE = 1;
    tick();
    n_total++;
    if ({mispredM, redirect_pcM} !== {1'b1, 32'h00400100})
      $display("FAIL mispred_nt: got mis=%b rpc=%h, want 1 00400100",
               mispredM, redirect_pcM);
    else n_pass++;
    idle(); tick();
    n_total++;
    if (mispredM !== 1'b0)
      $display("FAIL mispred_nt_once: got mis=%b, want 0", mispredM);
    else n_pass++;
  endtask

  task automatic test_wrap();
    idle(); put_br(1, 32'hFFFFFFF8, 32'h00001234);
    tick();
    idle(); actual_takeE = 0;
    tick();
    n_total++;
    if ({mispredM, actual_takeM, redirect_pcM} !==
        {1'b1, 1'b0, 32'h00000000})
      $display("FAIL wrap: got mis=%b act=%b rpc=%h, want 1 0 00000000",
               mispredM, actual_takeM, redirect_pcM);
    else n_pass++;
    idle(); tick();
  endtask

  task automatic test_stall_mispred();
    idle(); put_br(0, 32'h00400010, 32'h00400100);
    tick();
    idle(); actual_takeE = 1;
    tick();
    n_total++;
    if (mispredM !== 1'b1)
      $display("FAIL stall_first: got mis=%b, want 1", mispredM);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      idle(); stallM = 1; stallE = 1;
      put_br(1, 32'h0000_0aa0, 32'h0000_0bb0);
      tick();
      n_total++;
      if ({branchM, actual_takeM, pcM, mispredM, redirect_pcM} !==
          {1'b1, 1'b1, 32'h00400010, 1'b0, 32'h00400100})
        $display("FAIL stall_hold%0d: got br=%b act=%b pc=%h mis=%b rpc=%h, want 1 1 00400010 0 00400100",
                 i, branchM, actual_takeM, pcM, mispredM, redirect_pcM);
      else n_pass++;
    end
    idle(); tick();
    n_total++;
    if ({branchM, mispredM} !== 2'b00)
      $display("FAIL stall_release: got br=%b mis=%b, want 0 0",
               branchM, mispredM);
    else n_pass++;
    // Idle FSM must fire again for a fresh mispredict.
    put_br(1, 32'h00000040, 32'h00000080);
    tick();
    idle(); actual_takeE = 0;
    tick();
    n_total++;
    if ({mispredM, redirect_pcM} !== {1'b1, 32'h00000048})
      $display("FAIL stall_refire: got mis=%b rpc=%h, want 1 00000048",
               mispredM, redirect_pcM);
    else n_pass++;
    idle(); tick();
  endtask

  task automatic test_flush();
    idle(); put_br(0, 32'h00400010, 32'h00400100); flushE = 1;
    tick();
    idle(); actual_takeE = 1;
    tick();
    n_total++;
    if ({branchM, mispredM} !== 2'b00)
      $display("FAIL flushE: got br=%b mis=%b, want 0 0",
               branchM, mispredM);
    else n_pass++;
    idle(); put_br(0, 32'h00400020, 32'h00400200);
    tick();
    idle(); actual_takeE = 1;
    tick();
    flushM = 1;
    tick();
    n_total++;
    if ({branchM, mispredM, redirect_pcM} !== {2'b00, 32'h0})
      $display("FAIL flushM: got br=%b mis=%b rpc=%h, want 0 0 0",
               branchM, mispredM, redirect_pcM);
    else n_pass++;
    idle(); tick();
  endtask

`ifdef BRU_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [4:0] p = 5'b01101;
    logic [4:0] a = 5'b01011;
    idle(); rst = 1; tick(); idle();
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k < 5) put_br(p[k], 32'h100 + 32'(k * 4), 32'h800);
      if (k >= 1 && k <= 5) actual_takeE = a[k-1];
      tick();
    end
    n_total++;
    if ({br_cntM, mispred_cntM} !== {32'd5, 32'd2})
      $display("FAIL perf_cnt: got %0d/%0d, want 5/2",
               br_cntM, mispred_cntM);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst    = ($urandom_range(63) == 0);
      stallM = ($urandom_range(4) == 0);
      stallE = stallM | ($urandom_range(7) == 0);
      flushE = ($urandom_range(9) == 0);
      flushM = ($urandom_range(11) == 0);
      branchD = 1'($urandom);
      pred_takeD = 1'($urandom);
      pcD = ($urandom_range(7) == 0) ? 32'hFFFFFFF8
                                     : ($urandom & 32'hFFFFFFFC);
      targetD = $urandom & 32'hFFFFFFFC;
      actual_takeE = 1'($urandom);
      tick();
      n_total++;
      if ({branchM, actual_takeM, pcM, mispredM} !==
          {mm.br, mm.act, mm.pc, exp_mis()})
        $display("FAIL rand%0d: got br=%b act=%b pc=%h mis=%b, want %b %b %h %b",
                 i, branchM, actual_takeM, pcM, mispredM,
                 mm.br, mm.act, mm.pc, exp_mis());
      else n_pass++;
      if (mm.br) begin
        n_total++;
        if (redirect_pcM !== exp_redir())
          $display("FAIL rand_rpc%0d: got %h, want %h",
                   i, redirect_pcM, exp_redir());
        else n_pass++;
      end
`ifdef BRU_PERF_CNT_EN
      n_total++;
      if ({br_cntM, mispred_cntM} !== {cb, cm})
        $display("FAIL rand_cnt%0d: got %0d/%0d, want %0d/%0d",
                 i, br_cntM, mispred_cntM, cb, cm);
      else n_pass++;
`endif
    end
    idle();
  endtask

  initial begin
    me = '0; mm = '0; redirected = 0; cb = 0; cm = 0;
    idle();
    test_reset();
    test_correct_taken();
    test_mispred_not_taken();
    test_wrap();
    test_stall_mispred();
    test_flush();
`ifdef BRU_PERF_CNT_EN
    test_perf_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
